tcp_rx_flow_setup: RTL and testbench

TCP_RX_FLOW_SETUP -- requirements
Module: tcp_rx_flow_setup

---
 rtl/tcp_slow_pkg.sv | 33 +++
 rtl/flowid_free_list.sv | 56 +++++
 rtl/tcp_rx_flow_setup.sv | 192 +++++++++++++++++++
 tb/tb_tcp_rx_flow_setup.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tcp_slow_pkg.sv
// Shared definitions for the TCP receive slow path: default flow-ID width,
// TCP flag bit positions, the connection 4-tuple and the flow-setup FSM states.
package tcp_slow_pkg;

    localparam int FLOWID_W = 3;

    localparam int TCP_FLAG_SYN = 1;
    localparam int TCP_FLAG_RST = 2;
    localparam int TCP_FLAG_ACK = 4;

    typedef struct packed {
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } tcp_tuple_t;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_CHECK,
        S_CAM_WR,
        S_STATE_WR,
        S_SYNACK,
        S_DONE
    } flow_state_t;

    // A segment may open a flow only if it is a bare SYN (no ACK, no RST).
    function automatic logic is_syn_open(input logic [7:0] flags);
        return flags[TCP_FLAG_SYN] && !flags[TCP_FLAG_ACK] && !flags[TCP_FLAG_RST];
    endfunction

endpackage

// File: rtl/flowid_free_list.sv
// FIFO of unallocated flow IDs. Depth equals the number of flows, so it can
// never overflow when every ID is returned exactly once.
module flowid_free_list #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_id,
    input  logic         pop,
    output logic [W-1:0] head_id,
    output logic [W:0]   count,
    output logic         full,
    output logic         empty
);

    localparam int         DEPTH     = 1 << W;
    localparam logic [W:0] DEPTH_CNT = (W + 1)'(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head_id = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_id;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave the count alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tcp_rx_flow_setup.sv
// New-flow setup for the TCP receive slow path: admits bare SYNs, allocates a
// flow ID, programs the flow CAM and RX/TX state, then requests a SYN-ACK.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// INIT     | load every flow ID into the free list, one per cycle
// IDLE     | accept a new-flow request
// CHECK    | admit bare SYN with a free ID (pop it) or mark for drop
// CAM_WR   | insert tuple -> flowid into the flow CAM
// STATE_WR | initialise RX and TX state; each write retires independently
// SYNACK   | request SYN-ACK transmission
// DONE     | return completion with drop flag
module tcp_rx_flow_setup #(
    parameter int          FLOWID_W = tcp_slow_pkg::FLOWID_W,
    parameter logic [31:0] ISS      = 32'h0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                slow_path_val,
    output logic                slow_path_rdy,
    input  logic [95:0]         slow_path_tuple,
    input  logic [7:0]          slow_path_flags,
    input  logic [31:0]         slow_path_seq_num,
    output logic                slow_path_done_val,
    input  logic                slow_path_done_rdy,
    output logic                drop_pkt,
    output logic                cam_wr_val,
    input  logic                cam_wr_rdy,
    output logic [95:0]         cam_wr_tuple,
    output logic [FLOWID_W-1:0] cam_wr_flowid,
    output logic                new_rx_state_wr_val,
    input  logic                new_rx_state_wr_rdy,
    output logic [FLOWID_W-1:0] new_rx_state_flowid,
    output logic [31:0]         new_rx_state_rcv_nxt,
    output logic                new_tx_state_wr_val,
    input  logic                new_tx_state_wr_rdy,
    output logic [FLOWID_W-1:0] new_tx_state_flowid,
    output logic [31:0]         new_tx_state_snd_una,
    output logic                synack_req_val,
    input  logic                synack_req_rdy,
    output logic [FLOWID_W-1:0] synack_req_flowid,
    input  logic                flow_free_val,
    output logic                flow_free_rdy,
    input  logic [FLOWID_W-1:0] flow_free_id
);

    import tcp_slow_pkg::*;

    flow_state_t         state;
    logic [FLOWID_W-1:0] init_cnt;
    tcp_tuple_t          tuple_r;
    logic                syn_open_r;
    logic [31:0]         seq_r;
    logic [FLOWID_W-1:0] flowid_r;
    logic                drop_r;

    logic                fl_push;
    logic [FLOWID_W-1:0] fl_push_id;
    logic                fl_pop;
    logic [FLOWID_W-1:0] fl_head;
    logic [FLOWID_W:0]   fl_count;
    logic                fl_full;
    logic                fl_empty;
    logic                rx_finish;
    logic                tx_finish;

    // Free-list control: INIT owns the push port, otherwise returned IDs do.
    assign flow_free_rdy = (state != S_INIT) && !fl_full;
    assign fl_push       = (state == S_INIT) || (flow_free_val && flow_free_rdy);
    assign fl_push_id    = (state == S_INIT) ? init_cnt : flow_free_id;
    assign fl_pop        = (state == S_CHECK) && syn_open_r && !fl_empty;

    // A write is finished once its valid is down or it is being accepted now.
    assign rx_finish = !new_rx_state_wr_val || new_rx_state_wr_rdy;
    assign tx_finish = !new_tx_state_wr_val || new_tx_state_wr_rdy;

    // Data buses are held at zero whenever their valid is low.
    assign cam_wr_tuple         = cam_wr_val ? tuple_r : '0;
    assign cam_wr_flowid        = cam_wr_val ? flowid_r : '0;
    assign new_rx_state_flowid  = new_rx_state_wr_val ? flowid_r : '0;
    assign new_rx_state_rcv_nxt = new_rx_state_wr_val ? (seq_r + 32'd1) : '0;
    assign new_tx_state_flowid  = new_tx_state_wr_val ? flowid_r : '0;
    assign new_tx_state_snd_una = new_tx_state_wr_val ? ISS : '0;
    assign synack_req_flowid    = synack_req_val ? flowid_r : '0;

    flowid_free_list #(
        .W (FLOWID_W)
    ) u_free_list (
        .clk     (clk),
        .rst     (rst),
        .push    (fl_push),
        .push_id (fl_push_id),
        .pop     (fl_pop),
        .head_id (fl_head),
        .count   (fl_count),
        .full    (fl_full),
        .empty   (fl_empty)
    );

    // Flow-setup sequencer with registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_INIT;
            init_cnt            <= '0;
            tuple_r             <= '0;
            syn_open_r          <= 1'b0;
            seq_r               <= '0;
            flowid_r            <= '0;
            drop_r              <= 1'b0;
            slow_path_rdy       <= 1'b0;
            slow_path_done_val  <= 1'b0;
            drop_pkt            <= 1'b0;
            cam_wr_val          <= 1'b0;
            new_rx_state_wr_val <= 1'b0;
            new_tx_state_wr_val <= 1'b0;
            synack_req_val      <= 1'b0;
        end else begin
            case (state)
                S_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == '1) begin
                        slow_path_rdy <= 1'b1;
                        state         <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (slow_path_val) begin
                        tuple_r       <= slow_path_tuple;
                        syn_open_r    <= is_syn_open(slow_path_flags);
                        seq_r         <= slow_path_seq_num;
                        slow_path_rdy <= 1'b0;
                        state         <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (syn_open_r && !fl_empty) begin
                        flowid_r   <= fl_head;
                        drop_r     <= 1'b0;
                        cam_wr_val <= 1'b1;
                        state      <= S_CAM_WR;
                    end else begin
                        drop_r             <= 1'b1;
                        drop_pkt           <= 1'b1;
                        slow_path_done_val <= 1'b1;
                        state              <= S_DONE;
                    end
                end
                S_CAM_WR: begin
                    if (cam_wr_rdy) begin
                        cam_wr_val          <= 1'b0;
                        new_rx_state_wr_val <= 1'b1;
                        new_tx_state_wr_val <= 1'b1;
                        state               <= S_STATE_WR;
                    end
                end
                S_STATE_WR: begin
                    if (new_rx_state_wr_val && new_rx_state_wr_rdy) new_rx_state_wr_val <= 1'b0;
                    if (new_tx_state_wr_val && new_tx_state_wr_rdy) new_tx_state_wr_val <= 1'b0;
                    if (rx_finish && tx_finish) begin
                        synack_req_val <= 1'b1;
                        state          <= S_SYNACK;
                    end
                end
                S_SYNACK: begin
                    if (synack_req_rdy) begin
                        synack_req_val     <= 1'b0;
                        slow_path_done_val <= 1'b1;
                        drop_pkt           <= drop_r;
                        state              <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (slow_path_done_rdy) begin
                        slow_path_done_val <= 1'b0;
                        drop_pkt           <= 1'b0;
                        slow_path_rdy      <= 1'b1;
                        state              <= S_IDLE;
                    end
                end
                default: state <= S_INIT;
            endcase
        end
    end

    // An allocation must always find an ID waiting in the free list.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(fl_pop && fl_count == '0));
        end
    end

endmodule

// File: tb/tb_tcp_rx_flow_setup.sv
module tb_tcp_rx_flow_setup;

    localparam int          FW    = 3;
    localparam int          NFLOW = 1 << FW;
    localparam logic [31:0] ISS_V = 32'hC0DE_0001;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          slow_path_val = 1'b0;
    logic          slow_path_rdy;
    logic [95:0]   slow_path_tuple = '0;
    logic [7:0]    slow_path_flags = '0;
    logic [31:0]   slow_path_seq_num = '0;
    logic          slow_path_done_val;
    logic          slow_path_done_rdy = 1'b0;
    logic          drop_pkt;
    logic          cam_wr_val;
    logic          cam_wr_rdy = 1'b0;
    logic [95:0]   cam_wr_tuple;
    logic [FW-1:0] cam_wr_flowid;
    logic          new_rx_state_wr_val;
    logic          new_rx_state_wr_rdy = 1'b0;
    logic [FW-1:0] new_rx_state_flowid;
    logic [31:0]   new_rx_state_rcv_nxt;
    logic          new_tx_state_wr_val;
    logic          new_tx_state_wr_rdy = 1'b0;
    logic [FW-1:0] new_tx_state_flowid;
    logic [31:0]   new_tx_state_snd_una;
    logic          synack_req_val;
    logic          synack_req_rdy = 1'b0;
    logic [FW-1:0] synack_req_flowid;
    logic          flow_free_val = 1'b0;
    logic          flow_free_rdy;
    logic [FW-1:0] flow_free_id = '0;

    int checks   = 0;
    int failures = 0;

    // Reference model: the pool of unallocated IDs in FIFO order, and the IDs
    // currently handed out (candidates for returning).
    int free_q[$];
    int alloc_q[$];

    always #5 clk = ~clk;

    tcp_rx_flow_setup #(.FLOWID_W(FW), .ISS(ISS_V)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .slow_path_val        (slow_path_val),
        .slow_path_rdy        (slow_path_rdy),
        .slow_path_tuple      (slow_path_tuple),
        .slow_path_flags      (slow_path_flags),
        .slow_path_seq_num    (slow_path_seq_num),
        .slow_path_done_val   (slow_path_done_val),
        .slow_path_done_rdy   (slow_path_done_rdy),
        .drop_pkt             (drop_pkt),
        .cam_wr_val           (cam_wr_val),
        .cam_wr_rdy           (cam_wr_rdy),
        .cam_wr_tuple         (cam_wr_tuple),
        .cam_wr_flowid        (cam_wr_flowid),
        .new_rx_state_wr_val  (new_rx_state_wr_val),
        .new_rx_state_wr_rdy  (new_rx_state_wr_rdy),
        .new_rx_state_flowid  (new_rx_state_flowid),
        .new_rx_state_rcv_nxt (new_rx_state_rcv_nxt),
        .new_tx_state_wr_val  (new_tx_state_wr_val),
        .new_tx_state_wr_rdy  (new_tx_state_wr_rdy),
        .new_tx_state_flowid  (new_tx_state_flowid),
        .new_tx_state_snd_una (new_tx_state_snd_una),
        .synack_req_val       (synack_req_val),
        .synack_req_rdy       (synack_req_rdy),
        .synack_req_flowid    (synack_req_flowid),
        .flow_free_val        (flow_free_val),
        .flow_free_rdy        (flow_free_rdy),
        .flow_free_id         (flow_free_id)
    );

    function automatic void remove_alloc(input int id);
        for (int i = 0; i < alloc_q.size(); i++) begin
            if (alloc_q[i] == id) begin
                alloc_q.delete(i);
                return;
            end
        end
    endfunction

    // Reset, then watch the INIT fill: nothing ready for 8 cycles, rdy on the 9th.
    task automatic test_reset();
        logic exp_rdy;
        rst = 1'b1;
        slow_path_val = 1'b0;  flow_free_val = 1'b0;
        cam_wr_rdy = 1'b0;  new_rx_state_wr_rdy = 1'b0;  new_tx_state_wr_rdy = 1'b0;
        synack_req_rdy = 1'b0;  slow_path_done_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int cyc = 1; cyc <= NFLOW + 1; cyc++) begin
            exp_rdy = (cyc == NFLOW + 1);
            checks++;
            if (slow_path_rdy !== exp_rdy) begin
                failures++;
                $display("FAIL reset_rdy cycle %0d: slow_path_rdy=%b want %b", cyc, slow_path_rdy, exp_rdy);
            end
            checks++;
            if (flow_free_rdy !== 1'b0) begin
                failures++;
                $display("FAIL reset_free_rdy cycle %0d: flow_free_rdy=%b want 0", cyc, flow_free_rdy);
            end
            checks++;
            if ({cam_wr_val, new_rx_state_wr_val, new_tx_state_wr_val, synack_req_val,
                 slow_path_done_val, drop_pkt} !== 6'b0) begin
                failures++;
                $display("FAIL reset_valids cycle %0d: got %b want 000000", cyc,
                         {cam_wr_val, new_rx_state_wr_val, new_tx_state_wr_val, synack_req_val,
                          slow_path_done_val, drop_pkt});
            end
            if (cyc != NFLOW + 1) @(negedge clk);
        end
        free_q.delete();
        alloc_q.delete();
        for (int i = 0; i < NFLOW; i++) free_q.push_back(i);
    endtask

    // Return one ID while idle; accepted only if the pool is not full.
    task automatic free_flow(input int id);
        logic exp_rdy;
        exp_rdy = (free_q.size() < NFLOW);
        checks++;
        if (flow_free_rdy !== exp_rdy) begin
            failures++;
            $display("FAIL free_rdy id %0d: flow_free_rdy=%b want %b", id, flow_free_rdy, exp_rdy);
        end
        flow_free_val = 1'b1;
        flow_free_id  = FW'(id);
        @(posedge clk);
        @(negedge clk);
        flow_free_val = 1'b0;
        if (exp_rdy) begin
            free_q.push_back(id);
            remove_alloc(id);
        end
    endtask

    // One slow-path request, end to end, judged against the pool model.
    task automatic run_txn(input logic [7:0] flags, input logic [31:0] seq,
                           input int cam_stall, input int rx_stall, input int tx_stall,
                           input bit fic, input int fic_id);
        logic [95:0] tuple;
        bit          ok, got_done, waited, pend_free, pend_rdy, drop_seen;
        int          exp_id, size_before;
        int          cam_cnt, rx_cnt, tx_cnt, syn_cnt, field_err, order_err, max_ph, ph;
        int          rx_first, tx_first;
        string       first_bad;

        tuple = {$urandom, $urandom, $urandom};
        size_before = free_q.size();
        ok = flags[1] && !flags[4] && !flags[2] && (size_before > 0);
        exp_id = ok ? free_q.pop_front() : 0;
        cam_cnt = 0; rx_cnt = 0; tx_cnt = 0; syn_cnt = 0;
        field_err = 0; order_err = 0; max_ph = 0;
        rx_first = -1; tx_first = -1;
        first_bad = "";
        got_done = 0; drop_seen = 0; pend_free = 0; pend_rdy = 0;

        waited = 0;
        for (int i = 0; i < 50 && !waited; i++) begin
            if (slow_path_rdy === 1'b1) waited = 1;
            else @(negedge clk);
        end
        checks++;
        if (!waited) begin
            failures++;
            $display("FAIL txn_rdy_timeout: slow_path_rdy=%b want 1", slow_path_rdy);
            return;
        end

        slow_path_val = 1'b1;
        slow_path_tuple = tuple;
        slow_path_flags = flags;
        slow_path_seq_num = seq;
        @(posedge clk);
        @(negedge clk);
        slow_path_val = 1'b0;

        if (fic) begin
            pend_rdy = (size_before < NFLOW);
            checks++;
            if (flow_free_rdy !== pend_rdy) begin
                failures++;
                $display("FAIL check_free_rdy: flow_free_rdy=%b want %b", flow_free_rdy, pend_rdy);
            end
            flow_free_val = 1'b1;
            flow_free_id  = FW'(fic_id);
            pend_free = 1;
        end

        for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
            @(negedge clk);
            if (pend_free) begin
                flow_free_val = 1'b0;
                if (pend_rdy) begin
                    free_q.push_back(fic_id);
                    remove_alloc(fic_id);
                end
                pend_free = 0;
            end
            if (slow_path_rdy !== 1'b0) begin
                field_err++;
                if (first_bad == "") first_bad = "slow_path_rdy";
            end
            ph = 0;
            if (cam_wr_val) begin
                cam_cnt++; ph = 1;
                if (cam_wr_tuple !== tuple || cam_wr_flowid !== FW'(exp_id)) begin
                    field_err++;
                    if (first_bad == "") first_bad = "cam_fields";
                end
            end else if (cam_wr_tuple !== '0 || cam_wr_flowid !== '0) begin
                field_err++;
                if (first_bad == "") first_bad = "cam_idle_bus";
            end
            if (new_rx_state_wr_val) begin
                if (rx_first < 0) rx_first = cyc;
                rx_cnt++;
                if (ph != 0) order_err++;
                ph = 2;
                if (new_rx_state_flowid !== FW'(exp_id) || new_rx_state_rcv_nxt !== seq + 32'd1) begin
                    field_err++;
                    if (first_bad == "") first_bad = "rx_fields";
                end
            end else if (new_rx_state_flowid !== '0 || new_rx_state_rcv_nxt !== '0) begin
                field_err++;
                if (first_bad == "") first_bad = "rx_idle_bus";
            end
            if (new_tx_state_wr_val) begin
                if (tx_first < 0) tx_first = cyc;
                tx_cnt++;
                if (ph == 1) order_err++;
                ph = 2;
                if (new_tx_state_flowid !== FW'(exp_id) || new_tx_state_snd_una !== ISS_V) begin
                    field_err++;
                    if (first_bad == "") first_bad = "tx_fields";
                end
            end else if (new_tx_state_flowid !== '0 || new_tx_state_snd_una !== '0) begin
                field_err++;
                if (first_bad == "") first_bad = "tx_idle_bus";
            end
            if (synack_req_val) begin
                syn_cnt++;
                if (ph != 0) order_err++;
                ph = 3;
                if (synack_req_flowid !== FW'(exp_id)) begin
                    field_err++;
                    if (first_bad == "") first_bad = "synack_flowid";
                end
            end else if (synack_req_flowid !== '0) begin
                field_err++;
                if (first_bad == "") first_bad = "synack_idle_bus";
            end
            if (slow_path_done_val) begin
                if (ph != 0) order_err++;
                ph = 4;
                got_done = 1;
                drop_seen = drop_pkt;
            end else if (drop_pkt !== 1'b0) begin
                field_err++;
                if (first_bad == "") first_bad = "drop_outside_done";
            end
            if (ph != 0) begin
                if (ph < max_ph) order_err++;
                if (ph > max_ph) max_ph = ph;
            end
            cam_wr_rdy          = cam_wr_val && (cam_cnt > cam_stall);
            new_rx_state_wr_rdy = new_rx_state_wr_val && (rx_cnt > rx_stall);
            new_tx_state_wr_rdy = new_tx_state_wr_val && (tx_cnt > tx_stall);
            synack_req_rdy      = synack_req_val;
            slow_path_done_rdy  = slow_path_done_val;
        end

        checks++;
        if (!got_done) begin
            failures++;
            $display("FAIL txn_done_timeout: slow_path_done_val never seen");
            return;
        end
        @(posedge clk);
        @(negedge clk);
        cam_wr_rdy = 1'b0; new_rx_state_wr_rdy = 1'b0; new_tx_state_wr_rdy = 1'b0;
        synack_req_rdy = 1'b0; slow_path_done_rdy = 1'b0;

        checks++;
        if (drop_seen !== !ok) begin
            failures++;
            $display("FAIL drop_pkt flags=%h: got %b want %b", flags, drop_seen, !ok);
        end
        checks++;
        if (cam_cnt != (ok ? cam_stall + 1 : 0) || syn_cnt != (ok ? 1 : 0)) begin
            failures++;
            $display("FAIL cam_synack_cycles: cam=%0d synack=%0d want cam=%0d synack=%0d",
                     cam_cnt, syn_cnt, ok ? cam_stall + 1 : 0, ok ? 1 : 0);
        end
        checks++;
        if (rx_cnt != (ok ? rx_stall + 1 : 0) || tx_cnt != (ok ? tx_stall + 1 : 0) ||
            rx_first != tx_first) begin
            failures++;
            $display("FAIL state_wr_cycles: rx=%0d tx=%0d start %0d/%0d want rx=%0d tx=%0d same start",
                     rx_cnt, tx_cnt, rx_first, tx_first, ok ? rx_stall + 1 : 0, ok ? tx_stall + 1 : 0);
        end
        checks++;
        if (field_err != 0) begin
            failures++;
            $display("FAIL txn_fields: %0d bad samples, first %s, want 0 (expected flowid %0d)",
                     field_err, first_bad, exp_id);
        end
        checks++;
        if (order_err != 0) begin
            failures++;
            $display("FAIL txn_order: %0d phase overlaps/reversals want 0", order_err);
        end
        checks++;
        if (slow_path_done_val !== 1'b0 || slow_path_rdy !== 1'b1) begin
            failures++;
            $display("FAIL done_return: done_val=%b rdy=%b want 0/1", slow_path_done_val, slow_path_rdy);
        end
        if (ok) alloc_q.push_back(exp_id);
    endtask

    task automatic test_init_alloc();
        for (int i = 0; i < NFLOW; i++) run_txn(8'h02, $urandom, 0, 0, 0, 0, 0);
        checks++;
        if (alloc_q.size() != NFLOW) begin
            failures++;
            $display("FAIL init_alloc_count: %0d allocated want %0d", alloc_q.size(), NFLOW);
        end
    endtask

    task automatic test_list_empty();
        run_txn(8'h02, $urandom, 0, 0, 0, 0, 0);
        free_flow(5);
        run_txn(8'h02, $urandom, 1, 0, 0, 0, 0);
    endtask

    task automatic test_seq_wrap();
        free_flow(2);
        run_txn(8'h02, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    endtask

    task automatic test_ack_only();
        free_flow(3);
        run_txn(8'h10, $urandom, 0, 0, 0, 0, 0);
    endtask

    task automatic test_tx_stall();
        run_txn(8'h02, $urandom, 0, 0, 3, 0, 0);
    endtask

    task automatic test_free_in_check();
        free_flow(1);
        run_txn(8'h02, $urandom, 0, 0, 0, 1, 6);
        run_txn(8'h02, $urandom, 0, 1, 2, 0, 0);
        run_txn(8'h02, $urandom, 0, 0, 0, 0, 0);
        run_txn(8'h02, $urandom, 0, 0, 0, 1, 0);
        run_txn(8'h02, $urandom, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset_mid_transaction();
        bit seen;
        free_flow(4);
        cam_wr_rdy = 1'b1;
        new_rx_state_wr_rdy = 1'b0;
        new_tx_state_wr_rdy = 1'b0;
        slow_path_val = 1'b1;
        slow_path_flags = 8'h02;
        slow_path_seq_num = $urandom;
        @(posedge clk);
        @(negedge clk);
        slow_path_val = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (new_rx_state_wr_val === 1'b1) seen = 1;
            else @(negedge clk);
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL mid_reset_reach_state_wr: rx valid never seen");
        end
        cam_wr_rdy = 1'b0;
        test_reset();
        run_txn(8'h02, $urandom, 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        logic [7:0] flag_tab [6];
        logic [7:0] flags;
        int         idx, fid;
        bit         fic;
        flag_tab = '{8'h02, 8'h02, 8'h02, 8'h12, 8'h06, 8'h10};
        test_reset();
        for (int n = 0; n < 40; n++) begin
            if (alloc_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                idx = $urandom_range(0, alloc_q.size() - 1);
                free_flow(alloc_q[idx]);
            end
            fic = 0; fid = 0;
            if (alloc_q.size() > 0 && $urandom_range(0, 3) == 0) begin
                fic = 1;
                fid = alloc_q[$urandom_range(0, alloc_q.size() - 1)];
            end
            flags = flag_tab[$urandom_range(0, 5)] | (8'($urandom) & 8'hE9);
            run_txn(flags, $urandom, $urandom_range(0, 2), $urandom_range(0, 3),
                    $urandom_range(0, 3), fic, fid);
        end
    endtask

    initial begin
        test_reset();
        test_init_alloc();
        test_list_empty();
        test_seq_wrap();
        test_ack_only();
        test_tx_stall();
        test_free_in_check();
        test_reset_mid_transaction();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
